// File: rtl/fix_msg_delim_detect.sv
// FIX framing stage: writes every accepted byte into the message buffer at a
// wrapping pointer, detects "8=" message starts and "<SOH>10=ddd<SOH>" tails,
// verifies the checksum and emits start/end pulses with buffer addresses.
module fix_msg_delim_detect #(
    parameter int DATA_WIDTH = 5,
    parameter int MAX_LEN    = 31   // must be <= 2**DATA_WIDTH-1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [7:0]            data_i,
    output logic                  ready_o,
    input  logic                  full_i,
    output logic                  wr_en_o,
    output logic [DATA_WIDTH-1:0] wr_addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  start_message_o,
    output logic [DATA_WIDTH-1:0] start_addr_o,
    output logic                  end_message_o,
    output logic [DATA_WIDTH-1:0] end_addr_o,
    output logic                  err_o
);

    localparam int LEN_W = $clog2(MAX_LEN + 2);   // holds MAX_LEN+1
    localparam logic [LEN_W-1:0]      MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]      LEN_ONE   = LEN_W'(1);
    localparam logic [DATA_WIDTH-1:0] PTR_ONE   = DATA_WIDTH'(1);

    localparam logic [7:0] SOH    = 8'h01;
    localparam logic [7:0] CH_8   = 8'h38;
    localparam logic [7:0] CH_EQ  = 8'h3D;
    localparam logic [7:0] CH_1   = 8'h31;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAW8,
        S_BODY,
        S_TAG1,
        S_TAG0,
        S_TEQ,
        S_CK,
        S_CKSOH
    } state_t;

    // Registered state
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_start_ptr;
    logic [7:0]            r_sum;
    logic [7:0]            r_snap;
    logic [LEN_W-1:0]      r_len;
    logic [9:0]            r_val;
    logic [1:0]            r_dcnt;

    // Registered outputs
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_wr_addr;
    logic [7:0]            r_wr_data;
    logic                  r_start_msg;
    logic [DATA_WIDTH-1:0] r_start_addr;
    logic                  r_end_msg;
    logic [DATA_WIDTH-1:0] r_end_addr;
    logic                  r_err;

    // Next-state wires
    state_t                w_nxt_state;
    logic [DATA_WIDTH-1:0] w_nxt_start_ptr;
    logic [7:0]            w_nxt_sum;
    logic [7:0]            w_nxt_snap;
    logic [LEN_W-1:0]      w_nxt_len;
    logic [9:0]            w_nxt_val;
    logic [1:0]            w_nxt_dcnt;
    logic                  w_start_pls;
    logic                  w_end_pls;
    logic                  w_err;

    logic                  w_acc;
    logic                  w_is_digit;
    logic [7:0]            w_sum_inc;
    logic [LEN_W-1:0]      w_len_inc;
    logic [9:0]            w_val_acc;

    assign ready_o    = ~full_i;
    assign w_acc      = valid_i & ~full_i;
    assign w_is_digit = (data_i >= CH_0) && (data_i <= CH_9);
    assign w_sum_inc  = r_sum + data_i;
    assign w_len_inc  = r_len + LEN_ONE;
    assign w_val_acc  = (r_val * 10'd10) + {6'd0, data_i[3:0]};

    assign wr_en_o         = r_wr_en;
    assign wr_addr_o       = r_wr_addr;
    assign wr_data_o       = r_wr_data;
    assign start_message_o = r_start_msg;
    assign start_addr_o    = r_start_addr;
    assign end_message_o   = r_end_msg;
    assign end_addr_o      = r_end_addr;
    assign err_o           = r_err;

    // Framing FSM: next state, running sum/length/checksum and event pulses
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_start_ptr = r_start_ptr;
        w_nxt_sum       = r_sum;
        w_nxt_snap      = r_snap;
        w_nxt_len       = r_len;
        w_nxt_val       = r_val;
        w_nxt_dcnt      = r_dcnt;
        w_start_pls     = 1'b0;
        w_end_pls       = 1'b0;
        w_err           = 1'b0;

        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    if (data_i == CH_8) begin
                        w_nxt_state     = S_SAW8;
                        w_nxt_start_ptr = r_ptr;
                        w_nxt_sum       = data_i;
                        w_nxt_len       = LEN_ONE;
                    end
                end

                S_SAW8: begin
                    if (data_i == CH_EQ) begin
                        w_nxt_state = S_BODY;
                        w_start_pls = 1'b1;
                        w_nxt_sum   = w_sum_inc;
                        w_nxt_len   = w_len_inc;
                    end else if (data_i == CH_8) begin
                        // "88=": the second '8' is the real start
                        w_nxt_state     = S_SAW8;
                        w_nxt_start_ptr = r_ptr;
                        w_nxt_sum       = data_i;
                        w_nxt_len       = LEN_ONE;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end

                default: begin
                    // Inside a framed message: every byte counts toward sum and length
                    w_nxt_sum = w_sum_inc;
                    w_nxt_len = w_len_inc;
                    if (w_len_inc > MAX_LEN_L) begin
                        // Overlength wins over any tail progress
                        w_end_pls   = 1'b1;
                        w_err       = 1'b1;
                        w_nxt_state = S_IDLE;
                    end else begin
                        case (r_state)
                            S_BODY: begin
                                if (data_i == SOH) begin
                                    w_nxt_state = S_TAG1;
                                    w_nxt_snap  = w_sum_inc;
                                end
                            end
                            S_TAG1: begin
                                if (data_i == CH_1) begin
                                    w_nxt_state = S_TAG0;
                                end else if (data_i == SOH) begin
                                    w_nxt_state = S_TAG1;
                                    w_nxt_snap  = w_sum_inc;
                                end else begin
                                    w_nxt_state = S_BODY;
                                end
                            end
                            S_TAG0: begin
                                if (data_i == CH_0) begin
                                    w_nxt_state = S_TEQ;
                                end else if (data_i == SOH) begin
                                    w_nxt_state = S_TAG1;
                                    w_nxt_snap  = w_sum_inc;
                                end else begin
                                    w_nxt_state = S_BODY;
                                end
                            end
                            S_TEQ: begin
                                if (data_i == CH_EQ) begin
                                    w_nxt_state = S_CK;
                                    w_nxt_val   = 10'd0;
                                    w_nxt_dcnt  = 2'd0;
                                end else if (data_i == SOH) begin
                                    w_nxt_state = S_TAG1;
                                    w_nxt_snap  = w_sum_inc;
                                end else begin
                                    w_nxt_state = S_BODY;
                                end
                            end
                            S_CK: begin
                                if (w_is_digit) begin
                                    w_nxt_val  = w_val_acc;
                                    w_nxt_dcnt = r_dcnt + 2'd1;
                                    if (r_dcnt == 2'd2) begin
                                        w_nxt_state = S_CKSOH;
                                    end
                                end else begin
                                    w_end_pls   = 1'b1;
                                    w_err       = 1'b1;
                                    w_nxt_state = S_IDLE;
                                end
                            end
                            S_CKSOH: begin
                                // 10-bit compare: values above 255 never match
                                w_end_pls   = 1'b1;
                                w_err       = (data_i == SOH) ? (r_val != {2'b00, r_snap}) : 1'b1;
                                w_nxt_state = S_IDLE;
                            end
                            default: begin
                                w_nxt_state = S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // State, pointer and registered buffer-write / event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_start_ptr  <= '0;
            r_sum        <= '0;
            r_snap       <= '0;
            r_len        <= '0;
            r_val        <= '0;
            r_dcnt       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_start_msg  <= 1'b0;
            r_start_addr <= '0;
            r_end_msg    <= 1'b0;
            r_end_addr   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_start_ptr <= w_nxt_start_ptr;
            r_sum       <= w_nxt_sum;
            r_snap      <= w_nxt_snap;
            r_len       <= w_nxt_len;
            r_val       <= w_nxt_val;
            r_dcnt      <= w_nxt_dcnt;
            r_wr_en     <= w_acc;
            r_start_msg <= w_start_pls;
            r_end_msg   <= w_end_pls;
            r_err       <= w_err;
            if (w_acc) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= data_i;
                r_ptr     <= r_ptr + PTR_ONE;
            end
            if (w_start_pls) begin
                r_start_addr <= r_start_ptr;
            end
            if (w_end_pls) begin
                r_end_addr <= r_ptr;
            end
        end
    end

endmodule
